// File: rtl/spi_regmap_pkg.sv
// Register map, FSM encoding and reset defaults shared by the SPI register decoder.
package spi_regmap_pkg;

  localparam logic [3:0] ADDR_FREQ   = 4'd0;
  localparam logic [3:0] ADDR_DUTY   = 4'd1;
  localparam logic [3:0] ADDR_LED    = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;

  localparam int CMD_WRITE_BIT = 7;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_DATA_LO = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam logic [15:0] FREQ_RST_DEFAULT = 16'd490;
  localparam logic [15:0] DUTY_RST_DEFAULT = 16'd1250;
  localparam logic [7:0]  DEV_ID_DEFAULT   = 8'hA5;

  // Error counter increment that sticks at 255.
  function automatic logic [7:0] err_sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-stage single-bit synchroniser for an asynchronous input; flops reset to RST_VAL.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Never fewer than two flops, whatever the caller asks for.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {N{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[N-2:0], d};
    end
  end

  assign q = sync_reg[N-1];

endmodule

// File: rtl/spi_reg_decoder.sv
// Decodes the spi_slave byte stream into framed register reads/writes driving
// the pwm0 configuration and debug LEDs, and supplies the next tx byte.
module spi_reg_decoder
  import spi_regmap_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] FREQ_RST    = FREQ_RST_DEFAULT,
  parameter logic [15:0] DUTY_RST    = DUTY_RST_DEFAULT,
  parameter logic [7:0]  DEV_ID      = DEV_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss,
  input  logic        rx_byte_available,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tx_byte,
  output logic [15:0] pwm0_freq,
  output logic [15:0] pwm0_duty_cycle_usec,
  output logic [3:0]  led,
  output logic        cfg_update
);

  logic        ss_s;
  logic        ss_prev_reg;
  logic        rx_prev_reg;
  logic        ss_rise;
  logic        rx_evt;

  logic [2:0]  state_reg,  state_next;
  logic        cmd_wr_reg, cmd_wr_next;
  logic [3:0]  cmd_addr_reg, cmd_addr_next;
  logic [7:0]  lo_reg,     lo_next;
  logic [7:0]  rd_hi_reg,  rd_hi_next;
  logic [15:0] freq_reg,   freq_next;
  logic [15:0] duty_reg,   duty_next;
  logic [3:0]  led_reg,    led_next;
  logic [7:0]  err_reg,    err_next;
  logic [7:0]  tx_reg,     tx_next;
  logic        cfg_reg,    cfg_next;

  logic        err_inc_req;
  logic        err_clr_req;
  logic [15:0] rd_word;
  logic        rx_is_write;

  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ss),
    .q     (ss_s)
  );

  assign ss_rise     = ss_s & ~ss_prev_reg;
  assign rx_evt      = rx_byte_available & ~rx_prev_reg;
  assign rx_is_write = rx_byte[CMD_WRITE_BIT];

  // Read mux addressed by the incoming command byte; captured at byte0 so both halves agree.
  always_comb begin
    rd_word = 16'h0000;
    case (rx_byte[3:0])
      ADDR_FREQ:   rd_word = freq_reg;
      ADDR_DUTY:   rd_word = duty_reg;
      ADDR_LED:    rd_word = {12'h000, led_reg};
      ADDR_STATUS: rd_word = {err_reg, DEV_ID};
      default:     rd_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cmd_wr_next   = cmd_wr_reg;
    cmd_addr_next = cmd_addr_reg;
    lo_next       = lo_reg;
    rd_hi_next    = rd_hi_reg;
    freq_next     = freq_reg;
    duty_next     = duty_reg;
    led_next      = led_reg;
    tx_next       = tx_reg;
    cfg_next      = 1'b0;
    err_inc_req   = 1'b0;
    err_clr_req   = 1'b0;

    // Deselect beats any byte arriving in the same cycle.
    if (ss_rise) begin
      state_next = ST_IDLE;
      tx_next    = DEV_ID;
      if (cmd_wr_reg && (state_reg == ST_DATA_LO || state_reg == ST_DATA_HI)) begin
        err_inc_req = 1'b1;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!ss_s) state_next = ST_CMD;
        end
        ST_CMD: begin
          if (rx_evt) begin
            cmd_wr_next   = rx_is_write;
            cmd_addr_next = rx_byte[3:0];
            tx_next       = rx_is_write ? 8'h00 : rd_word[7:0];
            rd_hi_next    = rx_is_write ? 8'h00 : rd_word[15:8];
            state_next    = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (rx_evt) begin
            if (cmd_wr_reg) lo_next = rx_byte;
            tx_next    = cmd_wr_reg ? 8'h00 : rd_hi_reg;
            state_next = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (rx_evt) begin
            tx_next    = 8'h00;
            state_next = ST_DRAIN;
            if (cmd_wr_reg) begin
              cfg_next = 1'b1;
              case (cmd_addr_reg)
                ADDR_FREQ:   freq_next   = {rx_byte, lo_reg};
                ADDR_DUTY:   duty_next   = {rx_byte, lo_reg};
                ADDR_LED:    led_next    = lo_reg[3:0];
                ADDR_STATUS: err_clr_req = 1'b1;
                default: begin
                  cfg_next    = 1'b0;
                  err_inc_req = 1'b1;
                end
              endcase
            end
          end
        end
        ST_DRAIN: begin
          if (rx_evt) tx_next = 8'h00;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // A clear always wins over a simultaneous increment.
    if (err_clr_req)      err_next = 8'h00;
    else if (err_inc_req) err_next = err_sat_inc(err_reg);
    else                  err_next = err_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_prev_reg  <= 1'b1;
      rx_prev_reg  <= 1'b0;
      state_reg    <= ST_IDLE;
      cmd_wr_reg   <= 1'b0;
      cmd_addr_reg <= 4'h0;
      lo_reg       <= 8'h00;
      rd_hi_reg    <= 8'h00;
      freq_reg     <= FREQ_RST;
      duty_reg     <= DUTY_RST;
      led_reg      <= 4'h0;
      err_reg      <= 8'h00;
      tx_reg       <= DEV_ID;
      cfg_reg      <= 1'b0;
    end else begin
      ss_prev_reg  <= ss_s;
      rx_prev_reg  <= rx_byte_available;
      state_reg    <= state_next;
      cmd_wr_reg   <= cmd_wr_next;
      cmd_addr_reg <= cmd_addr_next;
      lo_reg       <= lo_next;
      rd_hi_reg    <= rd_hi_next;
      freq_reg     <= freq_next;
      duty_reg     <= duty_next;
      led_reg      <= led_next;
      err_reg      <= err_next;
      tx_reg       <= tx_next;
      cfg_reg      <= cfg_next;
    end
  end

  assign tx_byte              = tx_reg;
  assign pwm0_freq            = freq_reg;
  assign pwm0_duty_cycle_usec = duty_reg;
  assign led                  = led_reg;
  assign cfg_update           = cfg_reg;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Randomized frame-level bench for spi_reg_decoder with a per-frame register model
// compared against the outputs on every cycle outside reset.
module tb_spi_reg_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss = 1'b1;
  logic        rx_byte_available = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [7:0]  tx_byte;
  logic [15:0] pwm0_freq;
  logic [15:0] pwm0_duty_cycle_usec;
  logic [3:0]  led;
  logic        cfg_update;

  spi_reg_decoder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ss                   (ss),
    .rx_byte_available    (rx_byte_available),
    .rx_byte              (rx_byte),
    .tx_byte              (tx_byte),
    .pwm0_freq            (pwm0_freq),
    .pwm0_duty_cycle_usec (pwm0_duty_cycle_usec),
    .led                  (led),
    .cfg_update           (cfg_update)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cfg_pulses = 0;

  // Model: register contents plus the expected output pins.
  logic [15:0] m_freq, m_duty;
  logic [3:0]  m_led;
  logic [7:0]  m_err;
  logic [7:0]  exp_tx;
  logic        exp_cfg;
  logic [7:0]  m_cmd, m_lo;
  logic [15:0] m_snap;
  int          m_nbytes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] addr);
    case (addr)
      4'd0:    return m_freq;
      4'd1:    return m_duty;
      4'd2:    return {12'h000, m_led};
      4'd3:    return {m_err, 8'hA5};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] sat_plus(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  task automatic model_reset();
    m_freq = 16'd490; m_duty = 16'd1250; m_led = 4'h0; m_err = 8'h00;
    exp_tx = 8'hA5; exp_cfg = 1'b0; m_nbytes = 0; m_cmd = 8'h00; m_lo = 8'h00; m_snap = 16'h0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic wr;
    if (m_nbytes == 0) begin
      m_cmd  = b;
      m_snap = model_read(b[3:0]);
      exp_tx = b[7] ? 8'h00 : m_snap[7:0];
    end else if (m_nbytes == 1) begin
      m_lo   = b;
      exp_tx = m_cmd[7] ? 8'h00 : m_snap[15:8];
    end else begin
      exp_tx = 8'h00;
      if (m_nbytes == 2 && m_cmd[7]) begin
        wr = 1'b1;
        case (m_cmd[3:0])
          4'd0: m_freq = {b, m_lo};
          4'd1: m_duty = {b, m_lo};
          4'd2: m_led  = m_lo[3:0];
          4'd3: m_err  = 8'h00;
          default: begin m_err = sat_plus(m_err); wr = 1'b0; end
        endcase
        exp_cfg = wr;
      end
    end
    m_nbytes++;
  endtask

  task automatic model_end_frame();
    if (m_cmd[7] && (m_nbytes == 1 || m_nbytes == 2)) m_err = sat_plus(m_err);
    exp_tx   = 8'hA5;
    m_nbytes = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("freq", pwm0_freq, m_freq);
      check("duty", pwm0_duty_cycle_usec, m_duty);
      check("led", led, m_led);
      check("tx_byte", tx_byte, exp_tx);
      check("cfg_update", cfg_update, exp_cfg);
      if (cfg_update === 1'b1) cfg_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_byte_available = 1'b0;
    ss = 1'b1;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_byte_available = 1'b1;
    tick();
    model_byte(b);
    tick();
    exp_cfg = 1'b0;
    rx_byte_available = 1'b0;
    rx_byte = 8'($urandom);
    tick();
  endtask

  task automatic ss_low();
    ss = 1'b0;
    repeat (4) tick();
  endtask

  task automatic ss_high();
    ss = 1'b1;
    tick(); tick(); tick();
    model_end_frame();
    tick();
  endtask

  // Byte strobe lands in the same cycle the synchronised ss rises.
  task automatic ss_high_with_byte(input logic [7:0] b);
    ss = 1'b1;
    tick(); tick();
    rx_byte = b;
    rx_byte_available = 1'b1;
    tick();
    model_end_frame();
    rx_byte_available = 1'b0;
    tick(); tick();
  endtask

  task automatic write_frame(input logic [7:0] cmd, input logic [15:0] data);
    ss_low();
    send_byte(cmd);
    send_byte(data[7:0]);
    send_byte(data[15:8]);
    ss_high();
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [15:0] word);
    ss_low();
    send_byte({4'h0, addr});
    word[7:0] = tx_byte;
    send_byte(8'($urandom));
    word[15:8] = tx_byte;
    send_byte(8'($urandom));
    ss_high();
  endtask

  initial begin
    logic [15:0] word;
    logic [7:0]  cmd;
    int p0, nb;

    model_reset();
    do_reset();
    check("rst_freq", pwm0_freq, 32'd490);
    check("rst_duty", pwm0_duty_cycle_usec, 32'd1250);
    check("rst_led", led, 32'h0);
    check("rst_tx", tx_byte, 32'hA5);
    repeat (10) tick();
    check("rst_no_cfg", cfg_pulses, 32'd0);

    p0 = cfg_pulses;
    write_frame(8'h81, 16'h03E8);
    check("duty_1000", pwm0_duty_cycle_usec, 32'd1000);
    check("duty_one_pulse", cfg_pulses - p0, 32'd1);
    do_read(4'd3, word);
    check("duty_status", word, 32'h00A5);

    do_reset();
    ss_low();
    send_byte(8'h00);
    check("rd_tx_lo", tx_byte, 32'hEA);
    send_byte(8'h00);
    check("rd_tx_hi", tx_byte, 32'h01);
    send_byte(8'h00);
    check("rd_tx_zero", tx_byte, 32'h00);
    ss_high();
    check("rd_tx_devid", tx_byte, 32'hA5);

    do_reset();
    ss_low();
    send_byte(8'h80);
    send_byte(8'h10);
    ss_high();
    check("abort_freq", pwm0_freq, 32'd490);
    do_read(4'd3, word);
    check("abort_status", word, 32'h01A5);

    do_reset();
    write_frame(8'h89, 16'h1234);
    do_read(4'd3, word);
    check("bad_addr_status", word, 32'h01A5);
    write_frame(8'h83, 16'h0000);
    do_read(4'd3, word);
    check("clear_status", word, 32'h00A5);
    repeat (300) begin
      ss_low();
      send_byte(8'h80);
      ss_high();
    end
    do_read(4'd3, word);
    check("sat_status", word, 32'hFFA5);

    do_reset();
    ss_low();
    send_byte(8'h82);
    send_byte(8'h0F);
    ss_high_with_byte(8'h00);
    check("race_led", led, 32'h0);
    do_read(4'd3, word);
    check("race_status", word, 32'h01A5);
    p0 = cfg_pulses;
    ss_low();
    send_byte(8'h82);
    send_byte(8'h0F);
    send_byte(8'h00);
    send_byte(8'h55);
    ss_high();
    check("drain_led", led, 32'hF);
    check("drain_one_pulse", cfg_pulses - p0, 32'd1);

    ss_low();
    send_byte(8'h80);
    send_byte(8'h34);
    do_reset();
    check("midreset_freq", pwm0_freq, 32'd490);

    repeat (250) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) != 0) cmd[3:0] = 4'($urandom_range(0, 3));
      nb = $urandom_range(0, 4);
      ss_low();
      for (int i = 0; i < nb; i++) send_byte((i == 0) ? cmd : 8'($urandom));
      if (nb < 4 && $urandom_range(0, 3) == 0) ss_high_with_byte(8'($urandom));
      else ss_high();
      if ($urandom_range(0, 7) == 0) begin
        do_read(4'($urandom_range(0, 4)), word);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
